slave_config_ack_tx: RTL
========================

Name: slave_config_ack_tx

Overview:
- Downstream companion of the slave configuration frame parser.
- Consumes the parser's per-command valid pulses, its latched config values and `parse_error`, and serialises acknowledge/readback frames onto a byte stream towards the USB-CDC TX FIFO.
- Frame format matches the host-bound config protocol: A5, MOD, CMD, DATA, CHK, 5A, with CHK = MOD^CMD^DATA.
- Lets the host confirm every applied setting and learn of rejected frames.

Parameters:
- ACK_FLAG, 8'h80, ORed into the module byte of ack frames (SPI ack MOD=8'h81, I2C ack MOD=8'h82).
- ERR_MODULE, 8'hFF, MOD byte of an error frame.
- ERR_CMD, 8'hEE, CMD byte of an error frame.
- GAP_CYCLES, 0, idle clocks forced between the end of one frame and the next frame's first tx_valid (0..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- spi_mode_valid  in  1  pulse: SPI mode applied
- spi_cpol  in  1  current CPOL
- spi_cpha  in  1  current CPHA
- i2c_7b_addr_valid  in  1  pulse: 7-bit address applied
- i2c_slave_address  in  7  current 7-bit address
- i2c_reg_size_valid  in  1  pulse: register-address size applied
- i2c_reg_addr_16bit  in  1  current register-address size
- i2c_mode_valid  in  1  pulse: address mode applied
- i2c_enable_10bit_mode  in  1  current address mode
- i2c_10b_addr_valid  in  1  pulse: 10-bit address applied
- i2c_slave_10bit_address  in  10  current 10-bit address
- parse_error  in  1  pulse: frame rejected
- tx_data  out  8  byte to TX FIFO
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  TX FIFO accepts byte
- busy  out  1  frame in flight, or any event pending
- ack_overrun  out  1  pulse: ack event coalesced into an already-pending one

Behaviour:
- Interface: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - tx_data=8'h00, tx_valid=0, busy=0, ack_overrun=0.
  - All pending flags clear; err_cnt=0; FSM in IDLE.
  - Reset mid-frame drops the frame and all pending events.
- Pending flags (one per source: ERR, SPI, 7B, RSZ, MODE, 10B):
  - A flag sets on the clock its pulse is sampled high.
  - A flag clears on the clock its frame is loaded.
  - Pulse and load of the same source in the same cycle: the flag stays set, so a second frame follows.
- Coalescing:
  - An ack pulse for a source whose flag is already set (and not being loaded that cycle) leaves one pending event.
  - In that case ack_overrun is driven high for one cycle.
  - Frame data is sampled at load time, so the latest config value is reported.
- Error count:
  - err_cnt is 8 bits, saturates at 8'hFF, and increments on each parse_error.
  - On ERR frame load: DATA = err_cnt, and err_cnt becomes 0, or 1 if parse_error is high that same cycle.
  - Frames with DATA=0 are never sent.
- Load priority (fixed, highest first): ERR > SPI > 7B > RSZ > MODE > 10B.
- Frame contents:
  - SPI: MOD 8'h81, CMD 8'h01, DATA {6'b0,cpol,cpha}.
  - 7B: MOD 8'h82, CMD 8'h02, DATA {1'b0,addr7}.
  - RSZ: MOD 8'h82, CMD 8'h03, DATA {7'b0,reg16}.
  - MODE: MOD 8'h82, CMD 8'h04, DATA {7'b0,en10}.
  - 10B: MOD 8'h82, CMD 8'h06, DATA addr10[7:0]; MOD 8'h82, CMD 8'h05, DATA {6'b0,addr10[9:8]} follows as a second frame immediately after (after GAP), atomically. No other load may intervene.
  - ERR: MOD ERR_MODULE, CMD ERR_CMD, DATA err_cnt.
- FSM states:
  - IDLE: any flag set → LOAD next clock.
  - LOAD: latch MOD/CMD/DATA, compute CHK, clear the flag; tx_data=A5, tx_valid=1 from the next cycle → SEND.
  - SEND: 6-byte index 0..5. Advance only on tx_valid&&tx_ready. tx_data and tx_valid are held stable while stalled. After byte 5 is accepted: → GAP if GAP_CYCLES>0, else LOAD if any flag set (including a pending 10B-H half), else IDLE.
  - GAP: count GAP_CYCLES clocks with tx_valid=0, then → LOAD or IDLE.
- Latency:
  - Pulse sampled at edge k → flag high after k.
  - LOAD decision at edge k+1 → tx_valid high with A5 after edge k+1 (2 cycles).
  - With GAP_CYCLES=0 and tx_ready held high, back-to-back frames carry 1 bubble cycle (LOAD) between a 5A and the next A5.
- tx_valid never deasserts mid-frame, except on reset.
- busy = (state!=IDLE) | any flag.

Test Plan:
- spi_cpol=1, spi_cpha=0, spi_mode_valid pulse, tx_ready=1 → A5 81 01 02 82 5A; tx_valid first high 2 cycles after the pulse.
- i2c_slave_address=7'h50 pulse, tx_ready toggling 1/0 each cycle → A5 82 02 50 D0 5A; bytes held stable while tx_ready=0; no duplicates or drops.
- i2c_slave_10bit_address=10'h2B4 pulse → A5 82 06 B4 30 5A then A5 82 05 02 85 5A. A parse_error injected mid-first-frame is sent only after the second frame: A5 FF EE 01 10 5A.
- Same-cycle pulses of parse_error, spi_mode_valid and i2c_mode_valid → frames ordered ERR, SPI, MODE; three frames total.
- Two i2c_7b_addr_valid pulses (addr 0x10 then 0x20) while a frame stalls with tx_ready=0 → ack_overrun one pulse; one 7B frame with DATA 20.
- 300 parse_error pulses during a stall → error frame DATA FF (saturated). rst asserted mid-frame → tx_valid=0 next cycle, busy=0, no further output.

Source files
------------

// File: rtl/slave_config_ack_tx.sv
// -----------------------------------------------------------------------------
// slave_config_ack_tx
//   Turns the config parser's "setting applied" pulses and its parse_error
//   pulse into acknowledge/readback frames on a byte stream headed for the
//   USB-CDC TX FIFO. Frame layout: A5, MOD, CMD, DATA, CHK, 5A where
//   CHK = MOD ^ CMD ^ DATA.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   spi_mode_valid              pulse: SPI mode applied (reports cpol/cpha)
//   spi_cpol, spi_cpha          current SPI mode
//   i2c_7b_addr_valid           pulse: 7-bit address applied
//   i2c_slave_address           current 7-bit address
//   i2c_reg_size_valid          pulse: register-address size applied
//   i2c_reg_addr_16bit          current register-address size
//   i2c_mode_valid              pulse: address mode applied
//   i2c_enable_10bit_mode       current address mode
//   i2c_10b_addr_valid          pulse: 10-bit address applied
//   i2c_slave_10bit_address     current 10-bit address
//   parse_error                 pulse: frame rejected by the parser
//   tx_data, tx_valid, tx_ready  byte stream towards the TX FIFO
//   busy                        frame in flight or any event pending
//   ack_overrun                 pulse: ack event merged into a pending one
// -----------------------------------------------------------------------------
module slave_config_ack_tx #(
  parameter logic [7:0]  ACK_FLAG   = 8'h80,
  parameter logic [7:0]  ERR_MODULE = 8'hFF,
  parameter logic [7:0]  ERR_CMD    = 8'hEE,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_mode_valid,
  input  logic       spi_cpol,
  input  logic       spi_cpha,
  input  logic       i2c_7b_addr_valid,
  input  logic [6:0] i2c_slave_address,
  input  logic       i2c_reg_size_valid,
  input  logic       i2c_reg_addr_16bit,
  input  logic       i2c_mode_valid,
  input  logic       i2c_enable_10bit_mode,
  input  logic       i2c_10b_addr_valid,
  input  logic [9:0] i2c_slave_10bit_address,
  input  logic       parse_error,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       ack_overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // Pending-flag bit positions; lower index wins at load time.
  localparam int F_ERR  = 0;
  localparam int F_SPI  = 1;
  localparam int F_7B   = 2;
  localparam int F_RSZ  = 3;
  localparam int F_MODE = 4;
  localparam int F_10B  = 5;

  localparam logic [7:0] MOD_SPI = ACK_FLAG | 8'h01;
  localparam logic [7:0] MOD_I2C = ACK_FLAG | 8'h02;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  function automatic logic [7:0] frame_byte(input logic [2:0] i,
                                            input logic [7:0] m,
                                            input logic [7:0] c,
                                            input logic [7:0] d,
                                            input logic [7:0] k);
    case (i)
      3'd0:    frame_byte = 8'hA5;
      3'd1:    frame_byte = m;
      3'd2:    frame_byte = c;
      3'd3:    frame_byte = d;
      3'd4:    frame_byte = k;
      default: frame_byte = 8'h5A;
    endcase
  endfunction

  logic [1:0] state_q, state_d;
  logic [5:0] pend_q, pend_d;
  logic       hi_pend_q, hi_pend_d;
  logic [1:0] hi_bits_q, hi_bits_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] mod_q, mod_d, cmd_q, cmd_d, dat_q, dat_d, chk_q, chk_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       ovr_q, ovr_d;

  logic [5:0] pulse;
  logic       any_pend;
  logic       load_en;
  logic       accept;
  logic [5:0] load_clr;
  logic       hi_set;
  logic [7:0] sel_mod, sel_cmd, sel_dat;
  logic [7:0] err_base;

  assign pulse = {i2c_10b_addr_valid, i2c_mode_valid, i2c_reg_size_valid,
                  i2c_7b_addr_valid, spi_mode_valid, parse_error};

  // The second half of a 10-bit address readback counts as pending work.
  assign any_pend = (|pend_q) | hi_pend_q;
  // IDLE loads straight away so a pulse reaches tx_valid two clocks later;
  // LOAD is the one-cycle bubble between back-to-back frames.
  assign load_en  = ((state_q == S_IDLE) || (state_q == S_LOAD)) && any_pend;
  assign accept   = tx_valid_q && tx_ready;

  // Frame selection. A pending 10B high half pre-empts everything so the
  // two 10-bit frames always go out as an uninterrupted pair.
  always_comb begin
    load_clr = '0;
    hi_set   = 1'b0;
    sel_mod  = 8'h00;
    sel_cmd  = 8'h00;
    sel_dat  = 8'h00;
    if (hi_pend_q) begin
      sel_mod = MOD_I2C;
      sel_cmd = 8'h05;
      sel_dat = {6'b0, hi_bits_q};
    end else if (pend_q[F_ERR]) begin
      load_clr[F_ERR] = 1'b1;
      sel_mod = ERR_MODULE;
      sel_cmd = ERR_CMD;
      sel_dat = err_cnt_q;
    end else if (pend_q[F_SPI]) begin
      load_clr[F_SPI] = 1'b1;
      sel_mod = MOD_SPI;
      sel_cmd = 8'h01;
      sel_dat = {6'b0, spi_cpol, spi_cpha};
    end else if (pend_q[F_7B]) begin
      load_clr[F_7B] = 1'b1;
      sel_mod = MOD_I2C;
      sel_cmd = 8'h02;
      sel_dat = {1'b0, i2c_slave_address};
    end else if (pend_q[F_RSZ]) begin
      load_clr[F_RSZ] = 1'b1;
      sel_mod = MOD_I2C;
      sel_cmd = 8'h03;
      sel_dat = {7'b0, i2c_reg_addr_16bit};
    end else if (pend_q[F_MODE]) begin
      load_clr[F_MODE] = 1'b1;
      sel_mod = MOD_I2C;
      sel_cmd = 8'h04;
      sel_dat = {7'b0, i2c_enable_10bit_mode};
    end else if (pend_q[F_10B]) begin
      load_clr[F_10B] = 1'b1;
      hi_set  = 1'b1;
      sel_mod = MOD_I2C;
      sel_cmd = 8'h06;
      sel_dat = i2c_slave_10bit_address[7:0];
    end
    if (!load_en) begin
      load_clr = '0;
      hi_set   = 1'b0;
    end
  end

  always_comb begin
    // A pulse arriving on the cycle its own flag is loaded re-arms the flag.
    pend_d = (pend_q & ~load_clr) | pulse;

    // ERR is excluded: repeated errors accumulate in err_cnt instead.
    ovr_d = |(pulse[5:1] & pend_q[5:1] & ~load_clr[5:1]);

    err_base  = load_clr[F_ERR] ? 8'h00 : err_cnt_q;
    err_cnt_d = err_base;
    if (parse_error && (err_base != 8'hFF)) begin
      err_cnt_d = err_base + 8'd1;
    end

    hi_pend_d = hi_pend_q;
    hi_bits_d = hi_bits_q;
    if (hi_set) begin
      hi_pend_d = 1'b1;
      hi_bits_d = i2c_slave_10bit_address[9:8];
    end else if (load_en && hi_pend_q) begin
      hi_pend_d = 1'b0;
    end

    state_d    = state_q;
    mod_d      = mod_q;
    cmd_d      = cmd_q;
    dat_d      = dat_q;
    chk_d      = chk_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (load_en) begin
          mod_d      = sel_mod;
          cmd_d      = sel_cmd;
          dat_d      = sel_dat;
          chk_d      = sel_mod ^ sel_cmd ^ sel_dat;
          idx_d      = 3'd0;
          tx_data_d  = 8'hA5;
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (accept) begin
          if (idx_q == 3'd5) begin
            tx_valid_d = 1'b0;
            gap_d      = 8'd0;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
            end else begin
              state_d = any_pend ? S_LOAD : S_IDLE;
            end
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = frame_byte(idx_q + 3'd1, mod_q, cmd_q, dat_q, chk_q);
          end
        end
      end
      default: begin
        if (gap_q == GAP_LAST) begin
          state_d = any_pend ? S_LOAD : S_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      hi_pend_q  <= 1'b0;
      err_cnt_q  <= 8'h00;
      idx_q      <= 3'd0;
      gap_q      <= 8'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      hi_pend_q  <= hi_pend_d;
      err_cnt_q  <= err_cnt_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  // Frame contents; only meaningful while a frame is in flight
  always_ff @(posedge clk) begin
    mod_q     <= mod_d;
    cmd_q     <= cmd_d;
    dat_q     <= dat_d;
    chk_q     <= chk_d;
    hi_bits_q <= hi_bits_d;
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign ack_overrun = ovr_q;
  assign busy        = (state_q != S_IDLE) | any_pend;

endmodule
